// File: rtl/sram_like_pkg.sv
// sram_like_pkg: shared FSM state type and width helpers for the sram-like arbiter
package sram_like_pkg;
  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
  function automatic int grant_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  function automatic int strb_w(input int dw);
    return dw / 8;
  endfunction
endpackage

// File: rtl/sram_like_if.sv
// sram_like_if: sram-like master bus (req/addr_ok/data_ok) with master/slave modports
interface sram_like_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int STRB_W = sram_like_pkg::strb_w(DATA_W);
  logic              m_req;
  logic              m_wr;
  logic [STRB_W-1:0] m_wstrb;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic              m_addr_ok;
  logic              m_data_ok;
  logic [DATA_W-1:0] m_rdata;
  modport master (
    output m_req, m_wr, m_wstrb, m_addr, m_wdata,
    input  m_addr_ok, m_data_ok, m_rdata
  );
  modport slave (
    input  m_req, m_wr, m_wstrb, m_addr, m_wdata,
    output m_addr_ok, m_data_ok, m_rdata
  );
endinterface

// File: rtl/sram_like_rr_pick.sv
// sram_like_rr_pick: winner among pending channels; round-robin with SRAM_LIKE_ARB_RR_EN, else fixed priority
module sram_like_rr_pick #(
  parameter int NUM_CH  = 2,
  parameter int GRANT_W = 1
) (
  input  logic [NUM_CH-1:0]  pend,
`ifdef SRAM_LIKE_ARB_RR_EN
  input  logic [GRANT_W-1:0] last,
`endif
  output logic [NUM_CH-1:0]  win_oh,
  output logic [GRANT_W-1:0] win_idx,
  output logic               any
);
  logic [NUM_CH-1:0] cand;
`ifdef SRAM_LIKE_ARB_RR_EN
  logic [NUM_CH-1:0] upper;
  always_comb begin
    upper = '0;
    for (int i = 0; i < NUM_CH; i++) upper[i] = i > int'(last);
  end
  // channels above the last grant go first; wrap to the lowest index otherwise
  assign cand = |(pend & upper) ? (pend & upper) : pend;
`else
  assign cand = pend;
`endif
  always_comb begin
    win_oh  = '0;
    win_idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--)
      if (cand[i]) begin
        win_oh  = NUM_CH'(1) << i;
        win_idx = GRANT_W'(i);
      end
  end
  assign any = |pend;
endmodule

// File: rtl/sram_like_arbiter.sv
// sram_like_arbiter: NUM_CH stalling SRAM ports onto one sram-like master; SRAM_LIKE_ARB_RR_EN selects round-robin
module sram_like_arbiter
  import sram_like_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  localparam int STRB_W  = strb_w(DATA_W),
  localparam int GRANT_W = grant_w(NUM_CH)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_CH-1:0]              ch_en,
  input  logic [NUM_CH-1:0][STRB_W-1:0]  ch_wen,
  input  logic [NUM_CH-1:0][ADDR_W-1:0]  ch_addr,
  input  logic [NUM_CH-1:0][DATA_W-1:0]  ch_wdata,
  output logic [NUM_CH-1:0][DATA_W-1:0]  ch_rdata,
  output logic [NUM_CH-1:0]              ch_stall,
  output logic                           stall_all,
  sram_like_if.master                    bus
);
  state_t              state;
  logic [NUM_CH-1:0]   done, win_oh;
  logic [GRANT_W-1:0]  grant, win_idx;
  logic                any, resp;
  logic [STRB_W-1:0]   sel_wen;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;
  assign ch_stall  = ch_en & ~done;
  assign stall_all = |ch_stall;
  assign resp      = bus.m_data_ok & ((state == REQ & bus.m_addr_ok) | state == WAIT);
  sram_like_rr_pick #(.NUM_CH(NUM_CH), .GRANT_W(GRANT_W)) u_pick (
    .pend    (ch_stall),
`ifdef SRAM_LIKE_ARB_RR_EN
    .last    (grant),
`endif
    .win_oh  (win_oh),
    .win_idx (win_idx),
    .any     (any)
  );
  always_comb begin
    sel_wen   = '0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      sel_wen   |= ch_wen[i]   & {STRB_W{win_oh[i]}};
      sel_addr  |= ch_addr[i]  & {ADDR_W{win_oh[i]}};
      sel_wdata |= ch_wdata[i] & {DATA_W{win_oh[i]}};
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      grant       <= '0;
      done        <= '0;
      ch_rdata    <= '0;
      bus.m_req   <= 1'b0;
      bus.m_wr    <= 1'b0;
      bus.m_wstrb <= '0;
      bus.m_addr  <= '0;
      bus.m_wdata <= '0;
    end else begin
      case (state)
        IDLE: if (any) begin
          grant       <= win_idx;
          bus.m_req   <= 1'b1;
          bus.m_wr    <= |sel_wen;
          bus.m_wstrb <= sel_wen;
          bus.m_addr  <= sel_addr;
          bus.m_wdata <= sel_wdata;
          state       <= REQ;
        end
        REQ: if (bus.m_addr_ok) begin
          bus.m_req <= 1'b0;
          state     <= bus.m_data_ok ? IDLE : WAIT;
        end
        WAIT: if (bus.m_data_ok) state <= IDLE;
        default: state <= IDLE;
      endcase
      // a cycle with no stall means the pipeline advanced, so the window closes
      if (!stall_all) done <= '0;
      else if (resp) done[grant] <= 1'b1;
      if (resp && !bus.m_wr) ch_rdata[grant] <= bus.m_rdata;
    end
  end
  for (genvar i = 0; i < NUM_CH; i++) begin : g_hold
    a_hold: assert property (@(posedge clk) disable iff (rst) ch_stall[i] |=> ch_en[i]);
  end
endmodule

// File: tb/tb_sram_like_arbiter.sv
// tb_sram_like_arbiter: randomized scoreboard bench against a reference memory and arbitration model
module tb_sram_like_arbiter;
  localparam int N = 2;
  typedef logic [N-1:0][31:0] rvec_t;
  typedef struct {logic wr; logic [3:0] strb; logic [31:0] addr; logic [31:0] wdata;} acc_t;

  logic clk = 1'b0, rst;
  logic [N-1:0] ch_en, ch_stall;
  logic [N-1:0][3:0] ch_wen;
  rvec_t ch_addr, ch_wdata, ch_rdata;
  logic stall_all;
  sram_like_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  sram_like_arbiter #(.NUM_CH(N), .ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .ch_en(ch_en), .ch_wen(ch_wen), .ch_addr(ch_addr),
    .ch_wdata(ch_wdata), .ch_rdata(ch_rdata), .ch_stall(ch_stall),
    .stall_all(stall_all), .bus(bus)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;
  int a_fix = 0, d_fix = 0;
  int model_last = 0;
  bit win_open = 0;
  acc_t bus_q[$];
  rvec_t rd_q[$];
  rvec_t exp_rd = '0;
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] slave_mem [logic [31:0]];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic finish_run();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  endtask

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
    for (int b = 0; b < 4; b++) if (s[b]) o[8*b +: 8] = n[8*b +: 8];
    return o;
  endfunction

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  function automatic logic [31:0] slave_word(input logic [31:0] a);
    return slave_mem.exists(a) ? slave_mem[a] : init_word(a);
  endfunction

  function automatic int lat(input int f);
    return (f >= 0) ? f : int'($urandom_range(0, 7));
  endfunction

  task automatic respond(input logic wr, input logic [3:0] st, input logic [31:0] ad, input logic [31:0] wd);
    bus.m_data_ok = 1'b1;
    if (wr) begin
      slave_mem[ad] = merge(slave_word(ad), wd, st);
      bus.m_rdata = $urandom;
    end else bus.m_rdata = slave_word(ad);
  endtask

  // memory slave with configurable addr_ok / data_ok latency
  initial begin
    int a, d;
    logic s_wr;
    logic [3:0] s_st;
    logic [31:0] s_ad, s_wd;
    bus.m_addr_ok = 1'b0;
    bus.m_data_ok = 1'b0;
    bus.m_rdata = '0;
    forever begin
      @(negedge clk);
      if (rst || !bus.m_req) continue;
      a = lat(a_fix);
      d = lat(d_fix);
      repeat (a) @(negedge clk);
      s_wr = bus.m_wr; s_st = bus.m_wstrb; s_ad = bus.m_addr; s_wd = bus.m_wdata;
      bus.m_addr_ok = 1'b1;
      if (d == 0) respond(s_wr, s_st, s_ad, s_wd);
      @(negedge clk);
      bus.m_addr_ok = 1'b0;
      bus.m_data_ok = 1'b0;
      if (d > 0) begin
        repeat (d - 1) @(negedge clk);
        respond(s_wr, s_st, s_ad, s_wd);
        @(negedge clk);
        bus.m_data_ok = 1'b0;
      end
    end
  end

  // monitor: request stability, accepted accesses and captured read data
  logic hold = 1'b0;
  logic [68:0] prev;
  always begin
    acc_t e;
    rvec_t r;
    @(negedge clk);
    #2;
    if (rst) hold = 1'b0;
    else begin
      if (hold) chk("req_held", {bus.m_req, bus.m_wr, bus.m_wstrb, bus.m_addr, bus.m_wdata}, {1'b1, prev});
      hold = bus.m_req && !bus.m_addr_ok;
      prev = {bus.m_wr, bus.m_wstrb, bus.m_addr, bus.m_wdata};
      if (bus.m_req && bus.m_addr_ok) begin
        chk("bus_q_nonempty", bus_q.size() != 0, 1);
        if (bus_q.size() != 0) begin
          e = bus_q.pop_front();
          chk("bus_access", {bus.m_wr, bus.m_wstrb, bus.m_addr, bus.m_wdata}, {e.wr, e.strb, e.addr, e.wdata});
        end
      end
      if (win_open && !stall_all) begin
        chk("rd_q_nonempty", rd_q.size() != 0, 1);
        if (rd_q.size() != 0) begin
          r = rd_q.pop_front();
          chk("ch_rdata", ch_rdata, r);
        end
      end
    end
  end

  // reference model plans the window's access order and results, then the window is driven
  task automatic run_window(input logic [N-1:0] en, input logic [N-1:0][3:0] wen,
                            input rvec_t addr, input rvec_t wd, output int cyc);
    logic [N-1:0] left;
    int c;
    left = en;
    while (left != '0) begin
`ifdef SRAM_LIKE_ARB_RR_EN
      c = model_last;
      do c = (c + 1) % N; while (!left[c]);
`else
      c = 0;
      while (!left[c]) c++;
`endif
      left[c] = 1'b0;
      model_last = c;
      bus_q.push_back('{wen[c] != 4'b0, wen[c], addr[c], wd[c]});
      if (wen[c] != 4'b0) ref_mem[addr[c]] = merge(ref_word(addr[c]), wd[c], wen[c]);
      else exp_rd[c] = ref_word(addr[c]);
    end
    rd_q.push_back(exp_rd);
    ch_en = en; ch_wen = wen; ch_addr = addr; ch_wdata = wd;
    win_open = 1'b1;
    #1 chk("stall_follows_en", ch_stall, en);
    cyc = 0;
    forever begin
      @(negedge clk);
      if (!stall_all) break;
      cyc++;
      if (cyc > 400) begin
        n_chk++;
        $display("FAIL stall_release: stall_all still 1 after %0d cycles, expected 0", cyc);
        finish_run();
      end
    end
    @(posedge clk);
    #1;
    win_open = 1'b0;
    ch_en = '0;
  endtask

  initial begin
    #3_000_000;
    n_chk++;
    $display("FAIL watchdog: still running at %0t, expected completion", $time);
    finish_run();
  end

  initial begin
    logic [N-1:0][3:0] w;
    rvec_t a, d;
    logic [N-1:0] en;
    int cyc, nacc;
    rst = 1'b1; ch_en = '0; ch_wen = '0; ch_addr = '0; ch_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_m_req", bus.m_req, 0);
    chk("rst_m_wr", bus.m_wr, 0);
    chk("rst_m_wstrb", bus.m_wstrb, 0);
    chk("rst_m_addr", bus.m_addr, 0);
    chk("rst_m_wdata", bus.m_wdata, 0);
    chk("rst_ch_rdata", ch_rdata, 0);
    chk("rst_stall_all", stall_all, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // single read on ch1, addr_ok after 2 cycles, data_ok 3 later
    a_fix = 2; d_fix = 3;
    ref_mem[32'h1FC0_0010] = 32'hDEAD_BEEF;
    slave_mem[32'h1FC0_0010] = 32'hDEAD_BEEF;
    w = '0; a = '0; d = '0;
    a[1] = 32'h1FC0_0010;
    run_window(2'b10, w, a, d, cyc);
    chk("t1_stall_cycles", cyc, 7);
    chk("t1_rdata", ch_rdata[1], 32'hDEAD_BEEF);

    // ch0 read and ch1 write, zero-wait slave
    a_fix = 0; d_fix = 0;
    a[0] = 32'h0000_0100; a[1] = 32'h0000_0200;
    w[1] = 4'b0011; d[1] = 32'h1234_5678;
    run_window(2'b11, w, a, d, cyc);
    chk("t2_stall_cycles", cyc, 4);

    // addr_ok one cycle late, data_ok in the same cycle as addr_ok
    a_fix = 1; d_fix = 0;
    w = '0; a[0] = 32'h0000_0104; a[1] = 32'h0000_0200;
    run_window(2'b11, w, a, d, cyc);
    chk("t3_stall_cycles", cyc, 6);

    // reset while waiting for data_ok, then a stale data_ok right after reset
    a_fix = 0; d_fix = 2;
    bus_q.push_back('{1'b0, 4'b0, 32'h0000_0300, 32'h0});
    ch_wen = '0; ch_wdata = '0; ch_addr = '0;
    ch_addr[1] = 32'h0000_0300;
    ch_en = 2'b10;
    @(posedge clk);
    @(posedge clk);
    #1 chk("t4_wait_req", bus.m_req, 0);
    rst = 1'b1; ch_en = '0;
    @(posedge clk);
    #1 rst = 1'b0;
    model_last = 0;
    exp_rd = '0;
    @(negedge clk);
    chk("t4_req_after_rst", bus.m_req, 0);
    @(posedge clk);
    #1 chk("t4_rdata_after_stale", ch_rdata, 0);
    chk("t4_addr_after_rst", bus.m_addr, 0);
    chk("t4_req_idle", bus.m_req, 0);
    a[1] = 32'h0000_0300;
    run_window(2'b10, w, a, d, cyc);

    // both channels pending for four windows
    a_fix = -1; d_fix = -1;
    for (int k = 0; k < 4; k++) begin
      a[0] = 32'h0000_0400 + 32'(k * 8);
      a[1] = 32'h0000_0404 + 32'(k * 8);
      run_window(2'b11, w, a, d, cyc);
    end

    // random mixed traffic with random slave latency
    nacc = 0;
    while (nacc < 2000) begin
      en = N'($urandom_range(1, (1 << N) - 1));
      for (int i = 0; i < N; i++) begin
        w[i] = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(1, 15)) : 4'b0;
        a[i] = 32'h1000_0000 | (32'($urandom_range(0, 15)) << 2);
        d[i] = $urandom;
      end
      nacc += $countones(en);
      run_window(en, w, a, d, cyc);
    end
    repeat (4) @(posedge clk);
    chk("bus_q_drained", bus_q.size(), 0);
    chk("rd_q_drained", rd_q.size(), 0);
    finish_run();
  end
endmodule
